m20k_stream_fifo: RTL and testbench

//  Single-clock streaming FIFO around one internal MEMORY_M20K instance. Hides the M20K

---
 rtl/m20k_stream_fifo_if.sv | 36 +++
 rtl/m20k_stream_fifo.sv | 170 +++++++++++++++++
 tb/tb_m20k_stream_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/m20k_stream_fifo_if.sv
// Streaming FIFO bus: write side, valid/ready read side, occupancy and status.
//   master: producer/consumer side (drives writeEnable, dataIn, dataOutReady)
//   slave : FIFO side (drives dataOut, dataOutValid, usedw, flags, errors)
// Optional macro: M20K_STREAM_FIFO_STALL_COUNT_EN adds stallCycles.
interface m20k_stream_fifo_if #(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned DEPTH_LOG2 = 9
);
    logic                  writeEnable;
    logic [WIDTH-1:0]      dataIn;
    logic                  almostFull;
    logic                  full;
    logic [WIDTH-1:0]      dataOut;
    logic                  dataOutValid;
    logic                  dataOutReady;
    logic [DEPTH_LOG2:0]   usedw;
    logic                  overflowErr;
    logic                  eccErr;
`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
    logic [31:0]           stallCycles;

    modport master (output writeEnable, dataIn, dataOutReady,
                    input  almostFull, full, dataOut, dataOutValid, usedw,
                           overflowErr, eccErr, stallCycles);
    modport slave  (input  writeEnable, dataIn, dataOutReady,
                    output almostFull, full, dataOut, dataOutValid, usedw,
                           overflowErr, eccErr, stallCycles);
`else
    modport master (output writeEnable, dataIn, dataOutReady,
                    input  almostFull, full, dataOut, dataOutValid, usedw,
                           overflowErr, eccErr);
    modport slave  (input  writeEnable, dataIn, dataOutReady,
                    output almostFull, full, dataOut, dataOutValid, usedw,
                           overflowErr, eccErr);
`endif
endinterface

// File: rtl/m20k_stream_fifo.sv
// Single-clock streaming FIFO around one M20K-style memory (write commit delay,
// 3-cycle read latency) with a credit-managed register output buffer that
// sustains one word per cycle on a valid/ready output.
// Ports: clk, rst_n (synchronous, active-low), bus (m20k_stream_fifo_if.slave).
// Optional macro: M20K_STREAM_FIFO_STALL_COUNT_EN adds bus.stallCycles, a
// saturating count of cycles with dataOutValid && !dataOutReady.
module m20k_stream_fifo #(
    parameter int unsigned WIDTH              = 20,
    parameter int unsigned DEPTH_LOG2         = 9,
    parameter int unsigned ALMOST_FULL_MARGIN = 16,
    parameter int unsigned OUTPUT_BUF_DEPTH   = 8
) (
    input logic               clk,
    input logic               rst_n,
    m20k_stream_fifo_if.slave bus
);
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned CAP   = 2 ** DEPTH_LOG2;
    localparam int unsigned IDX_W = $clog2(OUTPUT_BUF_DEPTH);
    localparam int unsigned BCW   = $clog2(OUTPUT_BUF_DEPTH + 1);
    localparam logic        AF_RST = 1'(ALMOST_FULL_MARGIN >= CAP);

    // M20K model: contents and read pipeline are never reset
    logic [WIDTH-1:0] m20k_mem [CAP];
    logic [WIDTH-1:0] m20k_rd_q [3];
    logic             m20k_ecc_status;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] usedw_q, usedw_d, readable_cnt_q, readable_cnt_d;
    logic             wr_dly_q, wr_dly_d;
    logic [2:0]       vld_q, vld_d;
    logic [WIDTH-1:0] buf_mem_q [OUTPUT_BUF_DEPTH];
    logic [WIDTH-1:0] buf_mem_d [OUTPUT_BUF_DEPTH];
    logic [IDX_W-1:0] buf_head_q, buf_head_d, buf_tail_q, buf_tail_d;
    logic [BCW-1:0]   buf_count_q, buf_count_d;
    logic             full_q, full_d, almost_full_q, almost_full_d;
    logic             overflow_err_q, overflow_err_d, ecc_err_q, ecc_err_d;
`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
    logic [31:0]      stall_q, stall_d;
`endif

    logic             accept, pop, issue, capture;
    logic [1:0]       in_flight;

    // Memory: write commits at the edge; read data emerges 3 cycles after issue
    always_ff @(posedge clk) begin
        if (accept) m20k_mem[wr_ptr_q] <= bus.dataIn;
        if (issue)  m20k_rd_q[0] <= m20k_mem[rd_ptr_q];
        m20k_rd_q[1] <= m20k_rd_q[0];
        m20k_rd_q[2] <= m20k_rd_q[1];
    end
    assign m20k_ecc_status = 1'b0;

    // Next-state logic
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        usedw_d        = usedw_q;
        readable_cnt_d = readable_cnt_q;
        wr_dly_d       = 1'b0;
        vld_d          = vld_q;
        buf_mem_d      = buf_mem_q;
        buf_head_d     = buf_head_q;
        buf_tail_d     = buf_tail_q;
        buf_count_d    = buf_count_q;
        overflow_err_d = overflow_err_q;
        ecc_err_d      = ecc_err_q;

        accept    = bus.writeEnable && !full_q;
        pop       = (buf_count_q != '0) && bus.dataOutReady;
        capture   = vld_q[2];
        in_flight = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
        // Credits reserve a buffer slot for every read still in the pipeline
        issue     = (readable_cnt_q != '0) &&
                    ((32'(buf_count_q) + 32'(in_flight)) < OUTPUT_BUF_DEPTH);

        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (issue)  rd_ptr_d = rd_ptr_q + AW'(1);
        wr_dly_d       = accept;
        readable_cnt_d = readable_cnt_q + CNT_W'(wr_dly_q) - CNT_W'(issue);
        usedw_d        = usedw_q + CNT_W'(accept) - CNT_W'(pop);
        vld_d          = {vld_q[1:0], issue};

        if (capture) begin
            buf_mem_d[buf_tail_q] = m20k_rd_q[2];
            buf_tail_d = (buf_tail_q == IDX_W'(OUTPUT_BUF_DEPTH - 1)) ? '0 : buf_tail_q + IDX_W'(1);
        end
        if (pop) begin
            buf_head_d = (buf_head_q == IDX_W'(OUTPUT_BUF_DEPTH - 1)) ? '0 : buf_head_q + IDX_W'(1);
        end
        buf_count_d = buf_count_q + BCW'(capture) - BCW'(pop);

        full_d         = (usedw_d == CNT_W'(CAP));
        almost_full_d  = (32'(usedw_d) + ALMOST_FULL_MARGIN) >= CAP;
        overflow_err_d = overflow_err_q | (bus.writeEnable & full_q);
        ecc_err_d      = ecc_err_q | (capture & m20k_ecc_status);
    end

`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
    // Saturating stall counter
    always_comb begin
        stall_d = stall_q;
        if ((buf_count_q != '0) && !bus.dataOutReady && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end
`endif

    // Buffer payload needs no reset: buf_count_q gates its visibility
    always_ff @(posedge clk) begin
        buf_mem_q <= buf_mem_d;
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            usedw_q        <= '0;
            readable_cnt_q <= '0;
            wr_dly_q       <= 1'b0;
            vld_q          <= '0;
            buf_head_q     <= '0;
            buf_tail_q     <= '0;
            buf_count_q    <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= AF_RST;
            overflow_err_q <= 1'b0;
            ecc_err_q      <= 1'b0;
`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
            stall_q        <= '0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            usedw_q        <= usedw_d;
            readable_cnt_q <= readable_cnt_d;
            wr_dly_q       <= wr_dly_d;
            vld_q          <= vld_d;
            buf_head_q     <= buf_head_d;
            buf_tail_q     <= buf_tail_d;
            buf_count_q    <= buf_count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            overflow_err_q <= overflow_err_d;
            ecc_err_q      <= ecc_err_d;
`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
            stall_q        <= stall_d;
`endif
        end
    end

    // A return into a full buffer means the credit accounting is broken
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_no_buf_overflow: assert (!(capture && (32'(buf_count_q) == OUTPUT_BUF_DEPTH)));
        end
    end

    assign bus.dataOut      = buf_mem_q[buf_head_q];
    assign bus.dataOutValid = (buf_count_q != '0);
    assign bus.usedw        = usedw_q;
    assign bus.full         = full_q;
    assign bus.almostFull   = almost_full_q;
    assign bus.overflowErr  = overflow_err_q;
    assign bus.eccErr       = ecc_err_q;
`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
    assign bus.stallCycles  = stall_q;
`endif
endmodule

// File: tb/tb_m20k_stream_fifo.sv
// Directed bench for m20k_stream_fifo: reset, first-word latency, fill/overflow/
// drain, streaming, random back-pressure, mid-run reset, optional stall counter.
module tb_m20k_stream_fifo;
    localparam int unsigned WIDTH = 20;
    localparam int unsigned DL2   = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    m20k_stream_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) bus ();

    m20k_stream_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DL2), .ALMOST_FULL_MARGIN(16), .OUTPUT_BUF_DEPTH(8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, wr, ex, stale;
        logic rdy, stalled_prev;
        logic [WIDTH-1:0] prev_data;
        logic [DL2:0] prev_usedw;

        // Reset
        rst_n = 1'b0;
        bus.writeEnable = 1'b0;
        bus.dataIn = '0;
        bus.dataOutReady = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.dataOutValid, 0);
        check("rst_usedw", bus.usedw, 0);
        check("rst_full", bus.full, 0);
        check("rst_afull", bus.almostFull, 0);
        check("rst_ovf", bus.overflowErr, 0);
        check("rst_ecc", bus.eccErr, 0);
        rst_n = 1'b1;
        tick();

        // 1: first-word latency
        bus.dataOutReady = 1'b1;
        bus.writeEnable = 1'b1;
        bus.dataIn = 20'h12345;
        tick();
        bus.writeEnable = 1'b0;
        c = 1;
        while (!bus.dataOutValid && c < 20) begin tick(); c++; end
        check("t1_latency", 64'(c), 6);
        check("t1_data", bus.dataOut, 20'h12345);
        check("t1_usedw_busy", bus.usedw, 1);
        tick();
        check("t1_usedw_idle", bus.usedw, 0);
        check("t1_valid_idle", bus.dataOutValid, 0);

        // 2: fill to full, overflow, drain
        bus.dataOutReady = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus.writeEnable = 1'b1;
            bus.dataIn = 20'(i);
            tick();
            if (i + 1 == 495) check("t2_afull_495", bus.almostFull, 0);
            if (i + 1 == 496) check("t2_afull_496", bus.almostFull, 1);
            if (i + 1 == 511) check("t2_full_511", bus.full, 0);
        end
        check("t2_usedw_512", bus.usedw, 512);
        check("t2_full_512", bus.full, 1);
        bus.dataIn = 20'h77777;
        tick();
        bus.writeEnable = 1'b0;
        check("t2_ovf", bus.overflowErr, 1);
        check("t2_usedw_ovf", bus.usedw, 512);
        bus.dataOutReady = 1'b1;
        ex = 0;
        c = 0;
        while (ex < 512 && c < 2000) begin
            if (bus.dataOutValid) begin check("t2_order", bus.dataOut, 64'(ex)); ex++; end
            tick();
            c++;
        end
        check("t2_drained", 64'(ex), 512);
        repeat (10) tick();
        check("t2_valid_end", bus.dataOutValid, 0);
        check("t2_usedw_end", bus.usedw, 0);
        check("t2_full_end", bus.full, 0);

        // 3: continuous streaming, ready held high
        wr = 0;
        ex = 0;
        prev_usedw = bus.usedw;
        for (int cyc = 0; cyc < 3000 && ex < 2000; cyc++) begin
            if (wr < 2000) begin
                bus.writeEnable = 1'b1;
                bus.dataIn = 20'(wr + 1000);
            end else begin
                bus.writeEnable = 1'b0;
            end
            if (cyc >= 20 && cyc < 2000) begin
                check("t3_valid", bus.dataOutValid, 1);
                check("t3_usedw_stable", bus.usedw, prev_usedw);
            end
            if (bus.dataOutValid) begin check("t3_data", bus.dataOut, 64'(20'(ex + 1000))); ex++; end
            if (wr < 2000) wr++;
            prev_usedw = bus.usedw;
            tick();
        end
        bus.writeEnable = 1'b0;
        check("t3_count", 64'(ex), 2000);
        repeat (10) tick();
        check("t3_usedw_end", bus.usedw, 0);

        // 4: random back-pressure
        wr = 0;
        ex = 0;
        stalled_prev = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 40000 && ex < 5000; cyc++) begin
            bus.writeEnable = (wr < 5000) && !bus.full;
            bus.dataIn = 20'(wr * 7 + 3);
            if (bus.writeEnable) wr++;
            if (stalled_prev) begin
                check("t4_hold_valid", bus.dataOutValid, 1);
                check("t4_hold_data", bus.dataOut, prev_data);
            end
            rdy = 1'($urandom_range(0, 1));
            bus.dataOutReady = rdy;
            if (bus.dataOutValid && rdy) begin check("t4_data", bus.dataOut, 64'(20'(ex * 7 + 3))); ex++; end
            stalled_prev = bus.dataOutValid && !rdy;
            prev_data = bus.dataOut;
            tick();
        end
        bus.writeEnable = 1'b0;
        bus.dataOutReady = 1'b1;
        check("t4_count", 64'(ex), 5000);
        repeat (10) tick();
        check("t4_usedw_end", bus.usedw, 0);

        // 5: reset with reads in flight and words stored
        bus.dataOutReady = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.writeEnable = 1'b1;
            bus.dataIn = 20'(i + 20'h50000);
            tick();
        end
        bus.writeEnable = 1'b0;
        bus.dataOutReady = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", bus.dataOutValid, 0);
        check("t5_usedw", bus.usedw, 0);
        check("t5_ovf", bus.overflowErr, 0);
        check("t5_full", bus.full, 0);
        stale = 0;
        repeat (20) begin
            if (bus.dataOutValid) stale++;
            tick();
        end
        check("t5_no_stale", 64'(stale), 0);
        bus.writeEnable = 1'b1;
        bus.dataIn = 20'hABCDE;
        tick();
        bus.writeEnable = 1'b0;
        c = 1;
        while (!bus.dataOutValid && c < 20) begin tick(); c++; end
        check("t5_latency", 64'(c), 6);
        check("t5_data", bus.dataOut, 20'hABCDE);
        repeat (10) tick();
        check("t5_valid_end", bus.dataOutValid, 0);

`ifdef M20K_STREAM_FIFO_STALL_COUNT_EN
        // 6: stall counter
        bus.dataOutReady = 1'b0;
        check("t6_stall_init", bus.stallCycles, 0);
        bus.writeEnable = 1'b1;
        bus.dataIn = 20'h0BEEF;
        tick();
        bus.writeEnable = 1'b0;
        c = 1;
        while (!bus.dataOutValid && c < 20) begin tick(); c++; end
        check("t6_valid", bus.dataOutValid, 1);
        check("t6_stall_start", bus.stallCycles, 0);
        repeat (10) tick();
        check("t6_stall_10", bus.stallCycles, 10);
        bus.dataOutReady = 1'b1;
        tick();
        check("t6_stall_hold", bus.stallCycles, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
